resp_signature_checker: RTL and testbench

- Response-side counterpart to the random-stimulus driver: consumes the DUT output bus `y` once per accepted vector and compacts it into a 32-bit MISR signature.
- After N_VEC vectors, compares the signature against a golden value and reports pass/fail.
- Sits between the DUT `top` instance and the bench/regression harness; replaces per-cycle `$strobe` dumping with a synthesizable self-check.

---
 rtl/resp_signature_checker.sv | 204 ++++++++++++++++++++
 tb/tb_resp_signature_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_signature_checker.sv
// resp_signature_checker
// Compacts a stream of DUT response vectors into a MISR signature and, after
// N_VEC vectors, compares it against a golden value to give pass/fail.
//
// Handshake: a vector transfers on a rising clk edge where i_y_valid and
// o_y_ready are both 1. o_y_ready is high only while waiting for a vector
// (CAPTURE); the sender must hold i_y stable in that cycle. A valid seen while
// a run is in progress but o_y_ready is low (FOLD/CHECK) is dropped and
// latches the sticky o_overrun flag. Valid outside a run is ignored.
//
// N_VEC must be in 1..255 so the 8-bit vector counter never wraps.

`timescale 1ns/1ps

module resp_signature_checker #(
    parameter int                 Y_W   = 350,
    parameter int                 SIG_W = 32,
    parameter logic [SIG_W-1:0]   POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]   SEED  = 32'hFFFFFFFF,
    parameter int                 N_VEC = 21
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_y_valid,
    input  logic [Y_W-1:0]   i_y,
    output logic             o_y_ready,
    input  logic [SIG_W-1:0] i_exp_sig,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [SIG_W-1:0] o_sig,
    output logic [7:0]       o_vec_cnt,
    output logic             o_overrun,
    output logic [2:0]       o_state
);

    // Number of SIG_W chunks needed to cover the response bus; the top chunk
    // is zero-padded when Y_W is not a multiple of SIG_W.
    localparam int NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
    localparam int BUF_W  = NCHUNK * SIG_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCHUNK - 1);
    localparam logic [7:0]       N_VEC_CNT = 8'(N_VEC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_FOLD    = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BUF_W-1:0]   r_buf;
    logic [IDX_W-1:0]   r_idx;
    logic [SIG_W-1:0]   r_sig;
    logic [7:0]         r_vec_cnt;
    logic               r_pass;
    logic               r_overrun;

    logic [SIG_W-1:0]   w_chunk;
    logic [SIG_W-1:0]   w_fold;
    logic               w_last_chunk;
    logic [7:0]         w_vec_cnt_inc;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_drop;
    logic               w_y_ready;
    logic               w_busy;
    logic               w_done;

    // Datapath helpers: current chunk, one MISR step, run/handshake qualifiers.
    always_comb begin
        w_chunk       = r_buf[r_idx * SIG_W +: SIG_W];
        w_fold        = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ w_chunk;
        w_last_chunk  = (r_idx == LAST_IDX);
        w_vec_cnt_inc = r_vec_cnt + 8'd1;
        w_start_ok    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_accept      = i_y_valid && (r_state == S_CAPTURE);
        w_drop        = i_y_valid && ((r_state == S_FOLD) || (r_state == S_CHECK));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_y_ready   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_y_ready = 1'b1;
                w_busy    = 1'b1;
                if (i_y_valid) begin
                    w_state_nxt = S_FOLD;
                end
            end
            S_FOLD: begin
                w_busy = 1'b1;
                if (w_last_chunk) begin
                    w_state_nxt = (w_vec_cnt_inc == N_VEC_CNT) ? S_CHECK : S_CAPTURE;
                end
            end
            S_CHECK: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (i_start) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture buffer and chunk index: load on accept, step once per fold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_buf <= BUF_W'(i_y);
            r_idx <= '0;
        end else if (r_state == S_FOLD) begin
            r_idx <= w_last_chunk ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Signature register: seeded on start, one MISR step per FOLD cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sig <= '0;
        end else if (w_start_ok) begin
            r_sig <= SEED;
        end else if (r_state == S_FOLD) begin
            r_sig <= w_fold;
        end
    end

    // Vector counter: bumps once the last chunk of a vector is folded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vec_cnt <= '0;
        end else if (w_start_ok) begin
            r_vec_cnt <= '0;
        end else if ((r_state == S_FOLD) && w_last_chunk) begin
            r_vec_cnt <= w_vec_cnt_inc;
        end
    end

    // Pass flag: golden compare registered in CHECK, held through DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pass <= 1'b0;
        end else if (w_start_ok) begin
            r_pass <= 1'b0;
        end else if (r_state == S_CHECK) begin
            r_pass <= (r_sig == i_exp_sig);
        end
    end

    // Sticky overrun: a vector offered while the checker was folding/checking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_start_ok) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_y_ready = w_y_ready;
    assign o_busy    = w_busy;
    assign o_done    = w_done;
    assign o_pass    = r_pass;
    assign o_sig     = r_sig;
    assign o_vec_cnt = r_vec_cnt;
    assign o_overrun = r_overrun;
    assign o_state   = r_state;

endmodule

// File: tb/tb_resp_signature_checker.sv
// Directed bench for resp_signature_checker. Three instances share one set of
// inputs and differ only in parameters:
//   a: N_VEC=1, SEED=0          (single vector, padding, reset, restart)
//   b: N_VEC=2, SEED=0          (two vectors, held vs. pulsed valid)
//   c: N_VEC=1, SEED=80000000   (polynomial feedback)
// Inputs change just after the falling edge; outputs are sampled there too.

`timescale 1ns/1ps

module tb_resp_signature_checker;

  localparam int Y_W = 350;
  localparam int SIG_W = 32;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic             y_valid;
  logic [Y_W-1:0]   y;
  logic [SIG_W-1:0] exp_sig;

  logic             a_y_ready, a_busy, a_done, a_pass, a_overrun;
  logic [SIG_W-1:0] a_sig;
  logic [7:0]       a_vec_cnt;
  logic [2:0]       a_state;
  logic             b_y_ready, b_busy, b_done, b_pass, b_overrun;
  logic [SIG_W-1:0] b_sig;
  logic [7:0]       b_vec_cnt;
  logic [2:0]       b_state;
  logic             c_y_ready, c_busy, c_done, c_pass, c_overrun;
  logic [SIG_W-1:0] c_sig;
  logic [7:0]       c_vec_cnt;
  logic [2:0]       c_state;

  resp_signature_checker #(.Y_W(Y_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(32'h0), .N_VEC(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_y_valid(y_valid), .i_y(y),
    .o_y_ready(a_y_ready), .i_exp_sig(exp_sig), .o_busy(a_busy), .o_done(a_done),
    .o_pass(a_pass), .o_sig(a_sig), .o_vec_cnt(a_vec_cnt), .o_overrun(a_overrun),
    .o_state(a_state)
  );

  resp_signature_checker #(.Y_W(Y_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(32'h0), .N_VEC(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_y_valid(y_valid), .i_y(y),
    .o_y_ready(b_y_ready), .i_exp_sig(exp_sig), .o_busy(b_busy), .o_done(b_done),
    .o_pass(b_pass), .o_sig(b_sig), .o_vec_cnt(b_vec_cnt), .o_overrun(b_overrun),
    .o_state(b_state)
  );

  resp_signature_checker #(.Y_W(Y_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(32'h8000_0000), .N_VEC(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_y_valid(y_valid), .i_y(y),
    .o_y_ready(c_y_ready), .i_exp_sig(exp_sig), .o_busy(c_busy), .o_done(c_done),
    .o_pass(c_pass), .o_sig(c_sig), .o_vec_cnt(c_vec_cnt), .o_overrun(c_overrun),
    .o_state(c_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SIG_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_fold(input logic [31:0] s, input logic [31:0] chunk);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ chunk;
  endfunction

  function automatic logic sel_done(input int which);
    case (which)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_vec();
    y_valid = 1'b1;
    step(1);
    y_valid = 1'b0;
  endtask

  // Offer the current y to dut_b only once it signals ready.
  task automatic send_vec_b();
    int k;
    for (k = 0; k < 40; k++) begin
      if (b_y_ready) break;
      step(1);
    end
    check_eq("b_ready_wait", 32'(b_y_ready), 32'd1);
    pulse_vec();
  endtask

  task automatic wait_done(input int which, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (sel_done(which)) break;
      step(1);
    end
    check_eq("done_wait", 32'(sel_done(which)), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] m;
    rst = 1'b1; start = 1'b0; y_valid = 1'b0; y = '0; exp_sig = '0;
    step(2);
    check_eq("rst_sig",     a_sig, 32'h0);
    check_eq("rst_busy",    32'(a_busy), 32'd0);
    check_eq("rst_ready",   32'(a_y_ready), 32'd0);
    check_eq("rst_done",    32'(a_done), 32'd0);
    check_eq("rst_pass",    32'(a_pass), 32'd0);
    check_eq("rst_overrun", 32'(a_overrun), 32'd0);
    check_eq("rst_vec_cnt", 32'(a_vec_cnt), 32'd0);
    rst = 1'b0;

    // Single vector y=1: eleven folds shift the lone bit up to 0x400.
    exp_sig = 32'h400;
    exp_q.push_back(32'h0000_0400);
    do_start();
    check_eq("t1_ready", 32'(a_y_ready), 32'd1);
    check_eq("t1_busy",  32'(a_busy), 32'd1);
    y = '0; y[0] = 1'b1;
    pulse_vec();
    check_eq("t1_ready_fold", 32'(a_y_ready), 32'd0);
    start = 1'b1;   // ignored mid-run
    step(1);
    start = 1'b0;
    step(10);
    check_eq("t1_done_early", 32'(a_done), 32'd0);
    check_eq("t1_busy_check", 32'(a_busy), 32'd1);
    step(1);
    check_eq("t1_done",    32'(a_done), 32'd1);
    check_eq("t1_busy_end", 32'(a_busy), 32'd0);
    check_eq("t1_pass",    32'(a_pass), 32'd1);
    check_eq("t1_sig",     a_sig, exp_q.pop_front());
    check_eq("t1_vec_cnt", 32'(a_vec_cnt), 32'd1);
    check_eq("t1_overrun", 32'(a_overrun), 32'd0);
    step(3);
    check_eq("t1_done_hold", 32'(a_done), 32'd1);

    // Restart from DONE reloads the seed.
    do_start();
    check_eq("t2_restart_done", 32'(a_done), 32'd0);
    check_eq("t2_restart_sig",  a_sig, 32'h0);
    check_eq("t2_restart_rdy",  32'(a_y_ready), 32'd1);

    // Top-chunk padding: bit 320 lands in chunk 10, folded last.
    exp_sig = 32'h1;
    exp_q.push_back(32'h0000_0001);
    y = '0; y[320] = 1'b1;
    pulse_vec();
    wait_done(0, 20);
    check_eq("t2_sig",  a_sig, exp_q.pop_front());
    check_eq("t2_pass", 32'(a_pass), 32'd1);
    do_start();
    exp_sig = 32'h2;
    pulse_vec();
    wait_done(0, 20);
    check_eq("t2_pass_bad", 32'(a_pass), 32'd0);
    check_eq("t2_done_bad", 32'(a_done), 32'd1);
    check_eq("t2_sig_bad",  a_sig, 32'h1);

    // Two vectors, valid held high through FOLD.
    do_reset();
    exp_sig = 32'h0020_0400;
    exp_q.push_back(32'h0020_0400);
    do_start();
    y = '0; y[0] = 1'b1;
    y_valid = 1'b1;
    step(12);
    check_eq("t3_vec_cnt_mid", 32'(b_vec_cnt), 32'd1);
    check_eq("t3_ready_back",  32'(b_y_ready), 32'd1);
    check_eq("t3_overrun_mid", 32'(b_overrun), 32'd1);
    step(1);
    y_valid = 1'b0;
    check_eq("t3_ready_fold", 32'(b_y_ready), 32'd0);
    wait_done(1, 30);
    check_eq("t3_sig",     b_sig, exp_q.pop_front());
    check_eq("t3_vec_cnt", 32'(b_vec_cnt), 32'd2);
    check_eq("t3_overrun", 32'(b_overrun), 32'd1);
    check_eq("t3_pass",    32'(b_pass), 32'd1);

    // Two vectors with a clean handshake.
    do_reset();
    exp_q.push_back(32'h0020_0400);
    do_start();
    send_vec_b();
    send_vec_b();
    wait_done(1, 30);
    check_eq("t4_sig",     b_sig, exp_q.pop_front());
    check_eq("t4_vec_cnt", 32'(b_vec_cnt), 32'd2);
    check_eq("t4_overrun", 32'(b_overrun), 32'd0);
    check_eq("t4_pass",    32'(b_pass), 32'd1);

    // Reset on the fifth FOLD edge.
    do_reset();
    do_start();
    y = '0; y[0] = 1'b1;
    pulse_vec();
    step(4);
    check_eq("t5_sig_pre",  a_sig, 32'h8);
    check_eq("t5_busy_pre", 32'(a_busy), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t5_sig",     a_sig, 32'h0);
    check_eq("t5_busy",    32'(a_busy), 32'd0);
    check_eq("t5_ready",   32'(a_y_ready), 32'd0);
    check_eq("t5_vec_cnt", 32'(a_vec_cnt), 32'd0);
    y_valid = 1'b1;
    step(3);
    y_valid = 1'b0;
    check_eq("t5_idle_busy",    32'(a_busy), 32'd0);
    check_eq("t5_idle_sig",     a_sig, 32'h0);
    check_eq("t5_idle_overrun", 32'(a_overrun), 32'd0);
    check_eq("t5_idle_done",    32'(a_done), 32'd0);

    // Feedback: seed MSB set, zero vector.
    m = 32'h8000_0000;
    for (int i = 0; i < 11; i++) m = model_fold(m, 32'h0);
    exp_sig = m;
    exp_q.push_back(m);
    do_start();
    check_eq("t6_seed", c_sig, 32'h8000_0000);
    y = '0;
    pulse_vec();
    step(1);
    check_eq("t6_first_fold", c_sig, 32'h04C1_1DB7);
    wait_done(2, 20);
    check_eq("t6_sig",  c_sig, exp_q.pop_front());
    check_eq("t6_pass", 32'(c_pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
